// File: rtl/mic_pkg.sv
// Shared definitions for the microphone volume path (meter, LED bar, seven-segment blocks).
// Provides sample/amplitude widths, the meter state type and the mid-rail magnitude helper.
package mic_pkg;
   localparam int MIC_MID = 2048;
   localparam int MIC_W   = 12;
   localparam int AMP_W   = 11;
   localparam int LVL_W   = 4;

   typedef enum logic [0:0] {
      ACCUM   = 1'b0,
      PUBLISH = 1'b1
   } meter_state_t;

   // Distance from mid-rail; the single out-of-range case (sample 0 -> 2048) clips to 2047.
   function automatic logic [AMP_W-1:0] mic_magnitude(input logic [MIC_W-1:0] smp);
      logic [MIC_W-1:0] diff;
      if (smp >= 12'd2048) begin
         diff = smp - 12'd2048;
      end else begin
         diff = 12'd2048 - smp;
      end
      if (diff[MIC_W-1]) begin
         return 11'd2047;
      end else begin
         return diff[AMP_W-1:0];
      end
   endfunction
endpackage

// File: rtl/peak_hold_decay.sv
// Peak-hold level tracker: holds the highest published level for HOLD_WINDOWS
// windows, then decays one step per window down to zero.
module peak_hold_decay
   import mic_pkg::*;
#(
   parameter int HOLD_WINDOWS = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             update,
   input  logic [LVL_W-1:0] level,
   output logic [LVL_W-1:0] peak_level
);

   localparam logic [3:0] HOLD_INIT = 4'(HOLD_WINDOWS);

   logic [3:0] hold_r;

   // Peak register and hold counter, advanced once per published window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peak_level <= 4'd0;
         hold_r     <= 4'd0;
      end else if (update) begin
         if (level >= peak_level) begin
            peak_level <= level;
            hold_r     <= HOLD_INIT;
         end else if (hold_r != 4'd0) begin
            hold_r     <= hold_r - 4'd1;
         end else if (peak_level != 4'd0) begin
            peak_level <= peak_level - 4'd1;
         end
      end
   end

endmodule

// File: rtl/mic_volume_meter.sv
// Windowed microphone volume meter: magnitude, window maximum, level and peak hold.
// Optional build macro MIC_NOISE_GATE_EN zeroes magnitudes at or below NOISE_FLOOR.
module mic_volume_meter
   import mic_pkg::*;
#(
   parameter int WINDOW       = 4000,
`ifdef MIC_NOISE_GATE_EN
   parameter int NOISE_FLOOR  = 64,
`endif
   parameter int HOLD_WINDOWS = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_valid,
   input  logic [MIC_W-1:0] mic_in,
   output logic [AMP_W-1:0] amplitude,
   output logic [LVL_W-1:0] level,
   output logic [LVL_W-1:0] peak_level,
   output logic             level_valid
);

   localparam logic [15:0] LAST_CNT = 16'(WINDOW - 1);

   meter_state_t     state_r;
   meter_state_t     state_nxt_s;
   logic [15:0]      cnt_r;
   logic [AMP_W-1:0] win_max_r;
   logic [AMP_W-1:0] mag_raw_s;
   logic [AMP_W-1:0] mag_s;
   logic [AMP_W-1:0] max_s;
   logic             close_s;

   assign mag_raw_s = mic_magnitude(mic_in);

`ifdef MIC_NOISE_GATE_EN
   localparam logic [AMP_W-1:0] GATE_LVL = AMP_W'(NOISE_FLOOR);

   // Hiss suppression ahead of the window maximum
   always_comb begin
      mag_s = mag_raw_s;
      if (mag_raw_s <= GATE_LVL) begin
         mag_s = 11'd0;
      end else begin
         mag_s = mag_raw_s;
      end
   end
`else
   assign mag_s = mag_raw_s;
`endif

   assign max_s   = (mag_s > win_max_r) ? mag_s : win_max_r;
   assign close_s = sample_valid && (cnt_r == LAST_CNT);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ACCUM;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state: close the window on the sample that completes it
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ACCUM: begin
            if (close_s) begin
               state_nxt_s = PUBLISH;
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         PUBLISH: state_nxt_s = ACCUM;
         default: state_nxt_s = ACCUM;
      endcase
   end

   // Window accumulation and registered outputs; a PUBLISH-cycle sample opens the next window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r       <= 16'd0;
         win_max_r   <= 11'd0;
         amplitude   <= 11'd0;
         level       <= 4'd0;
         level_valid <= 1'b0;
      end else begin
         case (state_r)
            PUBLISH: begin
               amplitude   <= win_max_r;
               level       <= win_max_r[AMP_W-1:AMP_W-LVL_W];
               level_valid <= 1'b1;
               if (sample_valid) begin
                  win_max_r <= mag_s;
                  cnt_r     <= 16'd1;
               end else begin
                  win_max_r <= 11'd0;
                  cnt_r     <= 16'd0;
               end
            end
            ACCUM: begin
               level_valid <= 1'b0;
               if (sample_valid) begin
                  win_max_r <= max_s;
                  cnt_r     <= cnt_r + 16'd1;
               end
            end
            default: begin
               level_valid <= 1'b0;
            end
         endcase
      end
   end

   peak_hold_decay #(
      .HOLD_WINDOWS(HOLD_WINDOWS)
   ) u_peak (
      .clk       (clk),
      .rst       (rst),
      .update    (state_r == PUBLISH),
      .level     (win_max_r[AMP_W-1:AMP_W-LVL_W]),
      .peak_level(peak_level)
   );

endmodule
